hwpe_ctrl_regfile_arbiter: RTL and testbench
============================================

# hwpe_ctrl_regfile_arbiter

Round-robin arbiter that shares the single read/write port of the HWPE control register file among `NB_REQ` requesters, such as the peripheral config slave and the engine-side context loader. It grants at most one transaction per cycle. It drives the register file's read and write ports and returns read data to the winner one cycle later. An optional per-requester lock gives atomic multi-word sequences. It sits between the requester-side control logic and the register file.

## Interface
- `NB_REQ`, 2: number of requesters; ≥2.
- `ADDR_WIDTH`, 5: register file word-address width.
- `DATA_WIDTH`, 32: data width; multiple of 8.
- `NUM_BYTE`, `DATA_WIDTH/8`: byte enables per word.
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous soft clear; also wired to the register file's `clear`.
- `req`  in  NB_REQ  per-requester request.
- `lock`  in  NB_REQ  requester keeps ownership after its grant while high.
- `wen`  in  NB_REQ  per-requester direction: 1 = read, 0 = write.
- `add`  in  NB_REQ×ADDR_WIDTH  word address.
- `data`  in  NB_REQ×DATA_WIDTH  write data.
- `be`  in  NB_REQ×NUM_BYTE  byte enables for writes.
- `gnt`  out  NB_REQ  one-hot grant, same cycle as `req`.
- `r_valid`  out  NB_REQ  one-hot, one cycle after a granted read.
- `r_data`  out  DATA_WIDTH  read data, valid while any `r_valid` is high; 0 otherwise.
- `ReadEnable`, `ReadAddr`  out  1, ADDR_WIDTH  to the register file read port.
- `ReadData`  in  DATA_WIDTH  from the register file; depends on the registered read address.
- `WriteEnable`, `WriteAddr`, `WriteData`, `WriteBE`  out  1, ADDR_WIDTH, DATA_WIDTH, NUM_BYTE  to the register file write port.

## Operation
- **Handshake**
  - A requester raises `req` with stable `wen`/`add`/`data`/`be`/`lock`.
  - It holds them until `gnt`. The transaction completes on the `gnt` cycle.
  - It may deassert or change `req` in the cycle after `gnt`.
- **FSM states**
  - `IDLE`: round-robin. Winner is the first asserted `req` searching from pointer `ptr`, upward with wrap-around at `NB_REQ-1 → 0`.
  - On a grant to index `w`, `ptr <= (w+1) mod NB_REQ`.
  - If the winner has `lock=1`, the FSM goes to `LOCKED` with `owner <= w`.
  - `LOCKED`: only `owner` can be granted; other requesters stall.
  - In `LOCKED`, `ptr` is frozen at its value from the lock-taking grant.
  - A grant to `owner` with `lock=0` returns the FSM to `IDLE`. That final grant is still performed.
  - Owner `req=0` and `lock=0` in `LOCKED` also returns the FSM to `IDLE`, with no grant that cycle.
- **Port drive on a granted read**
  - `ReadEnable=1`, `ReadAddr=add[w]`, `WriteEnable=0`.
  - Next cycle: `r_valid[w]=1`, `r_data=ReadData`.
- **Port drive on a granted write**
  - `WriteEnable=1`, `WriteAddr`/`WriteData`/`WriteBE` taken from requester `w`, `ReadEnable=0`.
  - No `r_valid`.
- **No grant**: all enables are 0; address and data outputs are 0.
- **Read after write**
  - A write at cycle t followed by a read of the same word granted at t+1 returns the new data at t+2.
  - No bypass is needed, because the register file commits writes on the edge.
- **`clear`**
  - All `gnt` are 0 and both enables are 0 during `clear`.
  - Next edge: `ptr=0`, FSM=`IDLE`, `r_valid=0`.
- **Reset mid-lock**: on `rst_n` low, the FSM, `ptr`, `r_valid` and `owner` return to reset values immediately.

## Timing
- Reset values:
  - `gnt=0`, because nothing is granted while `rst_n` is low.
  - `r_valid=0`, `r_data=0`, `ptr=0`, `owner=0`, FSM=`IDLE`.
  - All register-file enables and fields are 0.
- `gnt` and the register-file port signals are combinational from `req`, `ptr` and the FSM, with zero-cycle latency.
- `r_valid` and the requester id are registered: read latency is exactly 1 cycle.
- Throughput is 1 transaction per cycle. Back-to-back reads from different requesters produce back-to-back `r_valid`.
- `r_data` is combinational from `ReadData`, gated by `|r_valid`.

## Structure
- Shared package `hwpe_ctrl_package`:
  - `regfile_arb_state_t` enum {`IDLE`, `LOCKED`}.
  - Constant `REGFILE_ARB_ID_WIDTH = $clog2(NB_REQ)`, the width of `ptr`, `owner` and the registered id.
- Sub-module `hwpe_ctrl_rr_picker`: purely combinational find-first-from-pointer with wrap-around. Inputs are the request vector and `ptr`; outputs are the one-hot grant and the winner index.
- The top level holds the FSM, `ptr`, `owner`, the `r_valid` register and the port muxing.

## Test plan
- Reset, then idle: all outputs are 0. `req=2'b01`, write of `0xDEADBEEF` at address 3 with `be=4'hF`: `gnt=01`, `WriteEnable=1`, `WriteAddr=3`, no `r_valid`.
- Read after write: requester 1 reads address 3 in the next cycle. `gnt=10`; one cycle later `r_valid=10` and `r_data=0xDEADBEEF`.
- Contention: both requesters issue 4 continuous reads. Grants alternate 01, 10, 01, 10 from `ptr=0`. `r_valid` follows one cycle behind, with no bubbles.
- Lock: requester 0 writes addresses 0..3 with `lock=1` on the first three and `lock=0` on the last, while requester 1 requests continuously. Requester 1 is not granted until requester 0's 4th grant completes; requester 1 is granted on the next cycle.
- Byte enables: a write of `0x11223344` with `be=4'b0101` over a word holding `0xAAAAAAAA`. A subsequent read returns `0xAA22AA44`.
- `clear` and reset during `LOCKED`: assert `clear` for 1 cycle. There is no grant that cycle. Next cycle the FSM is `IDLE`, `ptr=0`, and requester 1 can be granted. Repeat with `rst_n` pulsed low mid-read: `r_valid` drops to 0 asynchronously.

Source files
------------

// File: rtl/hwpe_ctrl_package.sv
// Shared types and helpers for the HWPE control register-file arbiter.
//   regfile_arb_state_t   : arbiter FSM state encoding
//   regfile_arb_id_width  : width of requester ids (ptr, owner, registered id)
package hwpe_ctrl_package;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } regfile_arb_state_t;

    // $clog2(nb_req), floored at 1 so an id is never zero bits wide.
    function automatic int unsigned regfile_arb_id_width(input int unsigned nb_req);
        return (nb_req > 32'd1) ? 32'($clog2(nb_req)) : 32'd1;
    endfunction

    localparam int unsigned REGFILE_ARB_NB_REQ   = 2;
    localparam int unsigned REGFILE_ARB_ID_WIDTH = regfile_arb_id_width(REGFILE_ARB_NB_REQ);

endpackage

// File: rtl/hwpe_ctrl_regfile_arbiter_if.sv
// Requester-side bus of the register-file arbiter.
//   req/lock/wen/add/data/be : per-requester transaction, driven by requesters
//   gnt/r_valid              : one-hot grant and read-valid back to requesters
//   r_data                   : shared read data
// master = requester side, slave = arbiter side.
interface hwpe_ctrl_regfile_arbiter_if #(
    parameter int unsigned NB_REQ     = 2,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_BYTE   = DATA_WIDTH / 8
);

    logic [NB_REQ-1:0]                 req;
    logic [NB_REQ-1:0]                 lock;
    logic [NB_REQ-1:0]                 wen;
    logic [NB_REQ-1:0][ADDR_WIDTH-1:0] add;
    logic [NB_REQ-1:0][DATA_WIDTH-1:0] data;
    logic [NB_REQ-1:0][NUM_BYTE-1:0]   be;
    logic [NB_REQ-1:0]                 gnt;
    logic [NB_REQ-1:0]                 r_valid;
    logic [DATA_WIDTH-1:0]             r_data;

    modport master (
        output req, lock, wen, add, data, be,
        input  gnt, r_valid, r_data
    );

    modport slave (
        input  req, lock, wen, add, data, be,
        output gnt, r_valid, r_data
    );

endinterface

// File: rtl/hwpe_ctrl_rr_picker.sv
// Combinational find-first-set starting at ptr, wrapping NB_REQ-1 -> 0.
//   req : request vector
//   ptr : search start index
//   gnt : one-hot winner (all zero when no request)
//   idx : winner index (0 when no request)
module hwpe_ctrl_rr_picker
    import hwpe_ctrl_package::*;
#(
    parameter int unsigned NB_REQ   = 2,
    parameter int unsigned ID_WIDTH = regfile_arb_id_width(NB_REQ)
) (
    input  logic [NB_REQ-1:0]   req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [NB_REQ-1:0]   gnt,
    output logic [ID_WIDTH-1:0] idx
);

    int unsigned       pos;
    logic [ID_WIDTH-1:0] pos_id;
    logic              found;

    // Walk the requests in priority order; the first hit wins.
    always_comb begin
        gnt    = '0;
        idx    = '0;
        found  = 1'b0;
        pos    = 32'd0;
        pos_id = '0;
        for (int unsigned i = 0; i < NB_REQ; i++) begin
            pos = 32'(ptr) + i;
            if (pos >= NB_REQ) begin
                pos = pos - NB_REQ;
            end
            pos_id = ID_WIDTH'(pos);
            if (!found && req[pos_id]) begin
                found       = 1'b1;
                gnt[pos_id] = 1'b1;
                idx         = pos_id;
            end
        end
    end

endmodule

// File: rtl/hwpe_ctrl_regfile_arbiter.sv
// Round-robin arbiter sharing the single read/write port of the HWPE control
// register file among NB_REQ requesters, with optional per-requester lock.
//   clk, rst_n, clear        : clock, async active-low reset, sync soft clear
//   bus (slave modport)      : requester handshake, grant, read return
//   ReadEnable/ReadAddr      : register-file read port
//   ReadData                 : register-file read data (registered address)
//   WriteEnable/WriteAddr/WriteData/WriteBE : register-file write port
module hwpe_ctrl_regfile_arbiter
    import hwpe_ctrl_package::*;
#(
    parameter int unsigned NB_REQ     = 2,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_BYTE   = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    hwpe_ctrl_regfile_arbiter_if.slave bus,
    output logic                  ReadEnable,
    output logic [ADDR_WIDTH-1:0] ReadAddr,
    input  logic [DATA_WIDTH-1:0] ReadData,
    output logic                  WriteEnable,
    output logic [ADDR_WIDTH-1:0] WriteAddr,
    output logic [DATA_WIDTH-1:0] WriteData,
    output logic [NUM_BYTE-1:0]   WriteBE
);

    localparam int unsigned ID_WIDTH = regfile_arb_id_width(NB_REQ);

    regfile_arb_state_t  state_q, state_d;
    logic [ID_WIDTH-1:0] ptr_q, ptr_d;
    logic [ID_WIDTH-1:0] owner_q, owner_d;
    logic [NB_REQ-1:0]   r_valid_q, r_valid_d;

    logic [NB_REQ-1:0]   owner_mask;
    logic [NB_REQ-1:0]   pick_req;
    logic [ID_WIDTH-1:0] pick_ptr;
    logic [NB_REQ-1:0]   pick_gnt;
    logic [ID_WIDTH-1:0] win_idx;
    logic [NB_REQ-1:0]   gnt;
    logic                grant_any;
    logic                read_grant;
    logic                write_grant;
    logic [ID_WIDTH-1:0] next_ptr;

    always_comb begin
        owner_mask          = '0;
        owner_mask[owner_q] = 1'b1;
    end

    // While locked, only the owner is visible to the picker and it searches
    // from the owner, so it can only ever pick the owner.
    always_comb begin
        pick_req = bus.req;
        pick_ptr = ptr_q;
        if (state_q == LOCKED) begin
            pick_req = bus.req & owner_mask;
            pick_ptr = owner_q;
        end
    end

    hwpe_ctrl_rr_picker #(
        .NB_REQ   (NB_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) i_picker (
        .req (pick_req),
        .ptr (pick_ptr),
        .gnt (pick_gnt),
        .idx (win_idx)
    );

    // Nothing is granted during reset or soft clear.
    always_comb begin
        gnt         = (rst_n && !clear) ? pick_gnt : '0;
        grant_any   = |gnt;
        read_grant  = grant_any &&  bus.wen[win_idx];
        write_grant = grant_any && !bus.wen[win_idx];
        next_ptr    = (win_idx == ID_WIDTH'(NB_REQ - 1)) ? '0 : win_idx + ID_WIDTH'(1);
    end

    // Register-file port mux; all fields forced to zero when not granted.
    always_comb begin
        ReadEnable  = read_grant;
        ReadAddr    = read_grant  ? bus.add[win_idx]  : '0;
        WriteEnable = write_grant;
        WriteAddr   = write_grant ? bus.add[win_idx]  : '0;
        WriteData   = write_grant ? bus.data[win_idx] : '0;
        WriteBE     = write_grant ? bus.be[win_idx]   : '0;
    end

    // Next-state: lock handover, pointer advance, read-valid id.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        r_valid_d = '0;
        if (clear) begin
            state_d = IDLE;
            ptr_d   = '0;
            owner_d = '0;
        end else begin
            if (read_grant) begin
                r_valid_d = gnt;
            end
            case (state_q)
                IDLE: begin
                    if (grant_any) begin
                        ptr_d = next_ptr;
                        if (bus.lock[win_idx]) begin
                            state_d = LOCKED;
                            owner_d = win_idx;
                        end
                    end
                end
                LOCKED: begin
                    // ptr stays frozen; release on an unlocked grant or an
                    // owner that has dropped both req and lock.
                    if (grant_any) begin
                        if (!bus.lock[owner_q]) begin
                            state_d = IDLE;
                        end
                    end else if (!bus.req[owner_q] && !bus.lock[owner_q]) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            r_valid_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            r_valid_q <= r_valid_d;
        end
    end

    assign bus.gnt     = gnt;
    assign bus.r_valid = r_valid_q;
    assign bus.r_data  = (|r_valid_q) ? ReadData : '0;

endmodule

// File: tb/tb_hwpe_ctrl_regfile_arbiter.sv
// Directed bench for hwpe_ctrl_regfile_arbiter with a behavioural register file
// (registered read address, byte-enabled write, cleared by clear/reset).
module tb_hwpe_ctrl_regfile_arbiter;

    localparam int unsigned NB_REQ = 2;
    localparam int unsigned AW     = 5;
    localparam int unsigned DW     = 32;
    localparam int unsigned NB     = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic          re;
    logic          we;
    logic [AW-1:0] ra;
    logic [AW-1:0] wa;
    logic [DW-1:0] rdata;
    logic [DW-1:0] wd;
    logic [NB-1:0] wbe;

    hwpe_ctrl_regfile_arbiter_if #(
        .NB_REQ     (NB_REQ),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_BYTE   (NB)
    ) bus ();

    hwpe_ctrl_regfile_arbiter #(
        .NB_REQ     (NB_REQ),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_BYTE   (NB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .bus         (bus),
        .ReadEnable  (re),
        .ReadAddr    (ra),
        .ReadData    (rdata),
        .WriteEnable (we),
        .WriteAddr   (wa),
        .WriteData   (wd),
        .WriteBE     (wbe)
    );

    always #5 clk = ~clk;

    // Register file model.
    logic [DW-1:0] mem [32];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
            for (int i = 0; i < 32; i++) mem[i] <= '0;
        end else if (clear) begin
            rdata <= '0;
            for (int i = 0; i < 32; i++) mem[i] <= '0;
        end else begin
            if (re) rdata <= mem[ra];
            if (we) begin
                for (int b = 0; b < int'(NB); b++) begin
                    if (wbe[b]) mem[wa][8*b +: 8] <= wd[8*b +: 8];
                end
            end
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic drive(input logic [1:0] r, input logic [1:0] l, input logic [1:0] w,
                         input logic [4:0] a0, input logic [4:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic [3:0] b0, input logic [3:0] b1);
        bus.req     = r;
        bus.lock    = l;
        bus.wen     = w;
        bus.add[0]  = a0;
        bus.add[1]  = a1;
        bus.data[0] = d0;
        bus.data[1] = d1;
        bus.be[0]   = b0;
        bus.be[1]   = b1;
    endtask

    task automatic idle();
        drive(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 4'h0, 4'h0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] exp_g;
    logic [1:0] prev_g;

    initial begin
        rst_n = 1'b0;
        clear = 1'b0;
        // Requests held during reset must not be granted.
        drive(2'b11, 2'b00, 2'b11, 5'd3, 5'd3, 32'h0, 32'h0, 4'hF, 4'hF);
        #12;
        check("rst_gnt",     bus.gnt,     2'b00);
        check("rst_rvalid",  bus.r_valid, 2'b00);
        check("rst_rdata",   bus.r_data,  32'h0);
        check("rst_re",      re,          1'b0);
        check("rst_raddr",   ra,          5'd0);
        check("rst_we",      we,          1'b0);
        check("rst_wfields", {wa, wd, wbe}, 41'h0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        check("idle_gnt", bus.gnt, 2'b00);
        check("idle_en",  {re, we}, 2'b00);

        // Requester 0 writes DEADBEEF to address 3.
        drive(2'b01, 2'b00, 2'b00, 5'd3, 5'd0, 32'hDEADBEEF, 32'h0, 4'hF, 4'h0);
        #1;
        check("wr_gnt",   bus.gnt, 2'b01);
        check("wr_we",    we,      1'b1);
        check("wr_waddr", wa,      5'd3);
        check("wr_wdata", wd,      32'hDEADBEEF);
        check("wr_wbe",   wbe,     4'hF);
        check("wr_re",    re,      1'b0);
        next_cycle();
        check("wr_rvalid", bus.r_valid, 2'b00);

        // Requester 1 reads address 3 right after the write.
        drive(2'b10, 2'b00, 2'b10, 5'd0, 5'd3, 32'h0, 32'h0, 4'h0, 4'h0);
        #1;
        check("raw_gnt",   bus.gnt, 2'b10);
        check("raw_re",    re,      1'b1);
        check("raw_raddr", ra,      5'd3);
        check("raw_we",    we,      1'b0);
        next_cycle();
        check("raw_rvalid", bus.r_valid, 2'b10);
        check("raw_rdata",  bus.r_data,  32'hDEADBEEF);

        // Requester 1 writes 12345678 to address 4 (ptr goes back to 0).
        drive(2'b10, 2'b00, 2'b00, 5'd0, 5'd4, 32'h0, 32'h12345678, 4'h0, 4'hF);
        #1;
        check("wr1_gnt",   bus.gnt, 2'b10);
        check("wr1_waddr", wa,      5'd4);
        next_cycle();

        // Contention: continuous reads from both, grants alternate from 01.
        drive(2'b11, 2'b00, 2'b11, 5'd3, 5'd4, 32'h0, 32'h0, 4'h0, 4'h0);
        prev_g = 2'b00;
        for (int k = 0; k < 8; k++) begin
            #1;
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            check("cont_gnt",    bus.gnt,     exp_g);
            check("cont_rvalid", bus.r_valid, prev_g);
            check("cont_rdata",  bus.r_data,
                  (prev_g == 2'b01) ? 32'hDEADBEEF : ((prev_g == 2'b10) ? 32'h12345678 : 32'h0));
            prev_g = exp_g;
            next_cycle();
        end
        idle();
        #1;
        check("cont_tail_gnt",    bus.gnt,     2'b00);
        check("cont_tail_rvalid", bus.r_valid, 2'b10);
        check("cont_tail_rdata",  bus.r_data,  32'h12345678);
        next_cycle();

        // Lock: requester 0 writes 0..3 locked, requester 1 waits.
        for (int k = 0; k < 4; k++) begin
            drive(2'b11, (k < 3) ? 2'b01 : 2'b00, 2'b10, 5'(k), 5'd4,
                  32'h100 + 32'(k), 32'h0, 4'hF, 4'h0);
            #1;
            check("lock_gnt",   bus.gnt, 2'b01);
            check("lock_waddr", wa,      5'(k));
            next_cycle();
        end
        drive(2'b10, 2'b00, 2'b10, 5'd0, 5'd4, 32'h0, 32'h0, 4'h0, 4'h0);
        #1;
        check("unlock_gnt", bus.gnt, 2'b10);
        check("unlock_re",  re,      1'b1);
        next_cycle();
        idle();
        #1;
        check("unlock_rvalid", bus.r_valid, 2'b10);
        check("unlock_rdata",  bus.r_data,  32'h12345678);
        next_cycle();

        // Owner keeps lock without req, then releases with no grant.
        drive(2'b01, 2'b01, 2'b00, 5'd8, 5'd0, 32'h55, 32'h0, 4'hF, 4'h0);
        #1;
        check("own_take_gnt", bus.gnt, 2'b01);
        next_cycle();
        drive(2'b10, 2'b01, 2'b10, 5'd0, 5'd4, 32'h0, 32'h0, 4'h0, 4'h0);
        #1;
        check("own_hold_gnt", bus.gnt, 2'b00);
        next_cycle();
        drive(2'b10, 2'b00, 2'b10, 5'd0, 5'd4, 32'h0, 32'h0, 4'h0, 4'h0);
        #1;
        check("own_rel_gnt", bus.gnt, 2'b00);
        next_cycle();
        #1;
        check("own_after_gnt", bus.gnt, 2'b10);
        next_cycle();

        // Byte enables over a word holding AAAAAAAA.
        drive(2'b01, 2'b00, 2'b00, 5'd5, 5'd0, 32'hAAAAAAAA, 32'h0, 4'hF, 4'h0);
        #1;
        check("be_fill_gnt", bus.gnt, 2'b01);
        next_cycle();
        drive(2'b01, 2'b00, 2'b00, 5'd5, 5'd0, 32'h11223344, 32'h0, 4'b0101, 4'h0);
        #1;
        check("be_wbe", wbe, 4'b0101);
        next_cycle();
        drive(2'b01, 2'b00, 2'b01, 5'd5, 5'd0, 32'h0, 32'h0, 4'h0, 4'h0);
        #1;
        check("be_raddr", ra, 5'd5);
        next_cycle();
        idle();
        #1;
        check("be_rvalid", bus.r_valid, 2'b01);
        check("be_rdata",  bus.r_data,  32'hAA22AA44);
        next_cycle();

        // Clear resets ptr (ptr is 1 here, so both requesting must give 01).
        clear = 1'b1;
        drive(2'b11, 2'b00, 2'b11, 5'd5, 5'd5, 32'h0, 32'h0, 4'h0, 4'h0);
        #1;
        check("clr_gnt", bus.gnt, 2'b00);
        check("clr_en",  {re, we}, 2'b00);
        next_cycle();
        clear = 1'b0;
        #1;
        check("clr_ptr_gnt", bus.gnt, 2'b01);
        next_cycle();

        // Clear while locked by requester 0.
        drive(2'b01, 2'b01, 2'b00, 5'd9, 5'd0, 32'h77, 32'h0, 4'hF, 4'h0);
        #1;
        check("clrlk_take_gnt", bus.gnt, 2'b01);
        next_cycle();
        clear = 1'b1;
        drive(2'b11, 2'b01, 2'b10, 5'd9, 5'd9, 32'h77, 32'h0, 4'hF, 4'h0);
        #1;
        check("clrlk_gnt", bus.gnt, 2'b00);
        check("clrlk_en",  {re, we}, 2'b00);
        next_cycle();
        clear = 1'b0;
        drive(2'b10, 2'b00, 2'b10, 5'd0, 5'd9, 32'h0, 32'h0, 4'h0, 4'h0);
        #1;
        check("clrlk_r1_gnt", bus.gnt, 2'b10);
        next_cycle();

        // Reset pulsed while a read is returning.
        drive(2'b10, 2'b00, 2'b00, 5'd0, 5'd7, 32'h0, 32'h5A5A5A5A, 4'h0, 4'hF);
        #1;
        check("rr_wr_gnt", bus.gnt, 2'b10);
        next_cycle();
        drive(2'b10, 2'b00, 2'b10, 5'd0, 5'd7, 32'h0, 32'h0, 4'h0, 4'h0);
        #1;
        check("rr_rd_gnt", bus.gnt, 2'b10);
        next_cycle();
        #1;
        check("rr_rvalid", bus.r_valid, 2'b10);
        check("rr_rdata",  bus.r_data,  32'h5A5A5A5A);
        rst_n = 1'b0;
        #1;
        check("rr_async_rvalid", bus.r_valid, 2'b00);
        check("rr_async_rdata",  bus.r_data,  32'h0);
        check("rr_async_gnt",    bus.gnt,     2'b00);
        check("rr_async_re",     re,          1'b0);
        idle();
        next_cycle();
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
